cfg_access_initiator: RTL

- Avalon-MM master that issues PCIe root-port configuration reads and writes on the config-space (cs) interface of the P-tile RP.
- The HPS drives each access through a small CSR slave on the h2f_lw bridge: it programs address, data and direction, then starts the access.
- The block drives the cs handshake, captures the response, and applies its own response timeout.
- It reports completion and error status in CSRs and on an interrupt line.

---
 rtl/cfg_init_pkg.sv | 32 +++
 rtl/cfg_init_csr_regs.sv | 139 +++++++++++++
 rtl/cfg_access_initiator.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/cfg_init_pkg.sv
// Shared types and constants for the config-space access initiator.
package cfg_init_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [2:0] CSR_CTRL    = 3'd0;
    localparam logic [2:0] CSR_ADDR    = 3'd1;
    localparam logic [2:0] CSR_WDATA   = 3'd2;
    localparam logic [2:0] CSR_BE      = 3'd3;
    localparam logic [2:0] CSR_RDATA   = 3'd4;
    localparam logic [2:0] CSR_STATUS  = 3'd5;
    localparam logic [2:0] CSR_TIMEOUT = 3'd6;

    localparam int STAT_BUSY          = 0;
    localparam int STAT_DONE          = 1;
    localparam int STAT_ERR_RESP      = 2;
    localparam int STAT_ERR_TIMEOUT   = 3;
    localparam int STAT_START_OVERRUN = 4;
    localparam int STAT_STALE_RESP    = 5;
    localparam int STAT_RESP_LSB      = 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [31:0] ALL_ONES_DATA = 32'hFFFF_FFFF;

endpackage

// File: rtl/cfg_init_csr_regs.sv
// HPS-facing register file: launch parameters, sticky W1C status, read mux.
module cfg_init_csr_regs
    import cfg_init_pkg::*;
#(
    parameter int ADDR_WIDTH      = 14,
    parameter int DATA_WIDTH      = 32,
    parameter int RESP_WIDTH      = 2,
    parameter int CSR_ADDR_WIDTH  = 3,
    parameter int CSR_DATA_WIDTH  = 32,
    parameter int TIMEOUT_DEFAULT = 5000000
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [CSR_ADDR_WIDTH-1:0] csr_address_i,
    input  logic                      csr_read_i,
    input  logic                      csr_write_i,
    input  logic [CSR_DATA_WIDTH-1:0] csr_writedata_i,
    output logic [CSR_DATA_WIDTH-1:0] csr_readdata_o,
    output logic                      csr_readdatavalid_o,
    input  logic                      busy_i,
    output logic                      start_o,
    output logic                      start_wr_o,
    output logic [ADDR_WIDTH-1:0]     addr_o,
    output logic [DATA_WIDTH-1:0]     wdata_o,
    output logic [DATA_WIDTH/8-1:0]   be_o,
    output logic [CSR_DATA_WIDTH-1:0] timeout_o,
    output logic                      done_o,
    output logic                      irq_en_o,
    input  logic                      rdata_we_i,
    input  logic [DATA_WIDTH-1:0]     rdata_i,
    input  logic                      done_set_i,
    input  logic                      err_resp_set_i,
    input  logic                      err_timeout_set_i,
    input  logic                      stale_set_i,
    input  logic [RESP_WIDTH-1:0]     resp_i
);

    logic                      wr_not_rd_q;
    logic [DATA_WIDTH-1:0]     rdata_q;
    logic                      err_resp_q;
    logic                      err_timeout_q;
    logic                      overrun_q;
    logic                      stale_q;
    logic [RESP_WIDTH-1:0]     last_resp_q;
    logic                      start_req;
    logic                      overrun_set;
    logic [CSR_DATA_WIDTH-1:0] w1c;
    logic [CSR_DATA_WIDTH-1:0] rd_mux;

    // Start strobe decode; a start while busy is only recorded as an overrun.
    always_comb begin
        start_req   = csr_write_i && (csr_address_i == CSR_CTRL) && csr_writedata_i[0];
        start_o     = start_req && !busy_i;
        overrun_set = start_req && busy_i;
        start_wr_o  = csr_writedata_i[1];
        w1c         = (csr_write_i && (csr_address_i == CSR_STATUS)) ? csr_writedata_i : '0;
    end

    // Register file and sticky status; a launch clears the previous result flags.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_not_rd_q   <= 1'b0;
            irq_en_o      <= 1'b0;
            addr_o        <= '0;
            wdata_o       <= '0;
            be_o          <= '1;
            timeout_o     <= CSR_DATA_WIDTH'(TIMEOUT_DEFAULT);
            rdata_q       <= '0;
            done_o        <= 1'b0;
            err_resp_q    <= 1'b0;
            err_timeout_q <= 1'b0;
            overrun_q     <= 1'b0;
            stale_q       <= 1'b0;
            last_resp_q   <= '0;
        end else begin
            if (csr_write_i && !busy_i) begin
                case (csr_address_i)
                    CSR_CTRL:  wr_not_rd_q <= csr_writedata_i[1];
                    CSR_ADDR:  addr_o      <= csr_writedata_i[ADDR_WIDTH-1:0];
                    CSR_WDATA: wdata_o     <= csr_writedata_i[DATA_WIDTH-1:0];
                    CSR_BE:    be_o        <= csr_writedata_i[DATA_WIDTH/8-1:0];
                    default:   ;
                endcase
            end
            if (csr_write_i && (csr_address_i == CSR_CTRL))
                irq_en_o <= csr_writedata_i[2];
            if (csr_write_i && (csr_address_i == CSR_TIMEOUT))
                timeout_o <= csr_writedata_i;
            if (rdata_we_i)
                rdata_q <= rdata_i;
            done_o        <= (done_o        & ~w1c[STAT_DONE]        & ~start_o) | done_set_i;
            err_resp_q    <= (err_resp_q    & ~w1c[STAT_ERR_RESP]    & ~start_o) | err_resp_set_i;
            err_timeout_q <= (err_timeout_q & ~w1c[STAT_ERR_TIMEOUT] & ~start_o) | err_timeout_set_i;
            overrun_q     <= (overrun_q     & ~w1c[STAT_START_OVERRUN]) | overrun_set;
            stale_q       <= (stale_q       & ~w1c[STAT_STALE_RESP])    | stale_set_i;
            if (done_set_i)
                last_resp_q <= resp_i;
        end
    end

    // Read mux; START always reads back as 0.
    always_comb begin
        rd_mux = '0;
        case (csr_address_i)
            CSR_CTRL: begin
                rd_mux[1] = wr_not_rd_q;
                rd_mux[2] = irq_en_o;
            end
            CSR_ADDR:    rd_mux[ADDR_WIDTH-1:0]   = addr_o;
            CSR_WDATA:   rd_mux[DATA_WIDTH-1:0]   = wdata_o;
            CSR_BE:      rd_mux[DATA_WIDTH/8-1:0] = be_o;
            CSR_RDATA:   rd_mux[DATA_WIDTH-1:0]   = rdata_q;
            CSR_STATUS: begin
                rd_mux[STAT_BUSY]          = busy_i;
                rd_mux[STAT_DONE]          = done_o;
                rd_mux[STAT_ERR_RESP]      = err_resp_q;
                rd_mux[STAT_ERR_TIMEOUT]   = err_timeout_q;
                rd_mux[STAT_START_OVERRUN] = overrun_q;
                rd_mux[STAT_STALE_RESP]    = stale_q;
                rd_mux[STAT_RESP_LSB +: RESP_WIDTH] = last_resp_q;
            end
            CSR_TIMEOUT: rd_mux = timeout_o;
            default:     ;
        endcase
    end

    // Fixed one-cycle read latency.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            csr_readdata_o      <= '0;
            csr_readdatavalid_o <= 1'b0;
        end else begin
            csr_readdatavalid_o <= csr_read_i;
            if (csr_read_i)
                csr_readdata_o <= rd_mux;
        end
    end

endmodule

// File: rtl/cfg_access_initiator.sv
// Avalon-MM master issuing root-port config reads/writes, driven from HPS CSRs.
module cfg_access_initiator
    import cfg_init_pkg::*;
#(
    parameter int ADDR_WIDTH      = 14,
    parameter int DATA_WIDTH      = 32,
    parameter int RESP_WIDTH      = 2,
    parameter int CSR_ADDR_WIDTH  = 3,
    parameter int CSR_DATA_WIDTH  = 32,
    parameter int TIMEOUT_DEFAULT = 5000000
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [CSR_ADDR_WIDTH-1:0] csr_address_i,
    input  logic                      csr_read_i,
    input  logic                      csr_write_i,
    input  logic [CSR_DATA_WIDTH-1:0] csr_writedata_i,
    output logic [CSR_DATA_WIDTH-1:0] csr_readdata_o,
    output logic                      csr_readdatavalid_o,
    output logic                      csr_waitrequest_o,
    output logic [ADDR_WIDTH-1:0]     cs_address_o,
    output logic                      cs_read_o,
    output logic                      cs_write_o,
    output logic [DATA_WIDTH-1:0]     cs_writedata_o,
    output logic [DATA_WIDTH/8-1:0]   cs_byteenable_o,
    input  logic                      cs_waitrequest_i,
    input  logic [DATA_WIDTH-1:0]     cs_readdata_i,
    input  logic                      cs_readdatavalid_i,
    input  logic                      cs_writeresponsevalid_i,
    input  logic [RESP_WIDTH-1:0]     cs_response_i,
    output logic                      busy_o,
    output logic                      irq_o
);

    state_t                    state_q;
    logic [31:0]               cnt_q;
    logic                      wr_q;
    logic                      tmo_hit_q;
    logic [RESP_WIDTH-1:0]     resp_q;

    logic                      start;
    logic                      start_wr;
    logic [ADDR_WIDTH-1:0]     addr;
    logic [DATA_WIDTH-1:0]     wdata;
    logic [DATA_WIDTH/8-1:0]   be;
    logic [CSR_DATA_WIDTH-1:0] timeout;
    logic                      done;
    logic                      irq_en;
    logic                      match;
    logic                      tmo;
    logic                      rdata_we;
    logic [DATA_WIDTH-1:0]     rdata_in;
    logic                      stale_set;

    assign csr_waitrequest_o = 1'b0;
    assign busy_o            = (state_q != IDLE);
    assign irq_o             = done & irq_en;

    // Response qualification; a valid coinciding with the timeout cycle wins.
    always_comb begin
        match     = (state_q == RESP) && (wr_q ? cs_writeresponsevalid_i : cs_readdatavalid_i);
        tmo       = (state_q == RESP) && (timeout != '0) && (cnt_q == timeout - 32'd1);
        rdata_we  = !wr_q && (match || tmo);
        rdata_in  = match ? cs_readdata_i : ALL_ONES_DATA;
        stale_set = (cs_readdatavalid_i      && !((state_q == RESP) && !wr_q)) ||
                    (cs_writeresponsevalid_i && !((state_q == RESP) &&  wr_q));
    end

    // Access sequencer: launch, hold request through waitrequest, await response.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            wr_q            <= 1'b0;
            tmo_hit_q       <= 1'b0;
            resp_q          <= '0;
            cs_address_o    <= '0;
            cs_read_o       <= 1'b0;
            cs_write_o      <= 1'b0;
            cs_writedata_o  <= '0;
            cs_byteenable_o <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        cs_address_o    <= addr;
                        cs_writedata_o  <= wdata;
                        cs_byteenable_o <= be;
                        cs_read_o       <= !start_wr;
                        cs_write_o      <= start_wr;
                        wr_q            <= start_wr;
                        tmo_hit_q       <= 1'b0;
                        state_q         <= REQ;
                    end
                end
                REQ: begin
                    if (!cs_waitrequest_i) begin
                        cs_read_o  <= 1'b0;
                        cs_write_o <= 1'b0;
                        cnt_q      <= '0;
                        state_q    <= RESP;
                    end
                end
                RESP: begin
                    if (match) begin
                        resp_q  <= cs_response_i;
                        state_q <= DONE;
                    end else if (tmo) begin
                        resp_q    <= RESP_SLVERR;
                        tmo_hit_q <= 1'b1;
                        state_q   <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    cfg_init_csr_regs #(
        .ADDR_WIDTH      (ADDR_WIDTH),
        .DATA_WIDTH      (DATA_WIDTH),
        .RESP_WIDTH      (RESP_WIDTH),
        .CSR_ADDR_WIDTH  (CSR_ADDR_WIDTH),
        .CSR_DATA_WIDTH  (CSR_DATA_WIDTH),
        .TIMEOUT_DEFAULT (TIMEOUT_DEFAULT)
    ) u_regs (
        .clk_i               (clk_i),
        .rst_i               (rst_i),
        .csr_address_i       (csr_address_i),
        .csr_read_i          (csr_read_i),
        .csr_write_i         (csr_write_i),
        .csr_writedata_i     (csr_writedata_i),
        .csr_readdata_o      (csr_readdata_o),
        .csr_readdatavalid_o (csr_readdatavalid_o),
        .busy_i              (busy_o),
        .start_o             (start),
        .start_wr_o          (start_wr),
        .addr_o              (addr),
        .wdata_o             (wdata),
        .be_o                (be),
        .timeout_o           (timeout),
        .done_o              (done),
        .irq_en_o            (irq_en),
        .rdata_we_i          (rdata_we),
        .rdata_i             (rdata_in),
        .done_set_i          (state_q == DONE),
        .err_resp_set_i      ((state_q == DONE) && (resp_q != RESP_OKAY)),
        .err_timeout_set_i   ((state_q == DONE) && tmo_hit_q),
        .stale_set_i         (stale_set),
        .resp_i              (resp_q)
    );

endmodule
